// File: rtl/alu_exec_ctrl_if.sv
// Bundle of issue-side request/response signals and the ALU_32 drive/return
// signals used by the multicycle execute sequencer.
interface alu_exec_ctrl_if;
  logic        start;
  logic [4:0]  FS;
  logic [4:0]  SHAMT;
  logic [31:0] S;
  logic [31:0] T;
  logic        ready;
  logic        done;
  logic        div0;
  logic [31:0] alu_S;
  logic [31:0] alu_T;
  logic [4:0]  alu_FS;
  logic [4:0]  alu_SHAMT;
  logic [31:0] alu_Y_hi;
  logic [31:0] alu_Y_lo;
  logic        alu_C;
  logic        alu_V;
  logic        alu_N;
  logic        alu_Z;
  logic [31:0] result;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        C;
  logic        V;
  logic        N;
  logic        Z;

  // Requester plus ALU_32 side of the link.
  modport master (
    output start, FS, SHAMT, S, T,
    output alu_Y_hi, alu_Y_lo, alu_C, alu_V, alu_N, alu_Z,
    input  ready, done, div0, alu_S, alu_T, alu_FS, alu_SHAMT,
    input  result, HI, LO, C, V, N, Z
  );

  // Sequencer side of the link.
  modport slave (
    input  start, FS, SHAMT, S, T,
    input  alu_Y_hi, alu_Y_lo, alu_C, alu_V, alu_N, alu_Z,
    output ready, done, div0, alu_S, alu_T, alu_FS, alu_SHAMT,
    output result, HI, LO, C, V, N, Z
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multicycle execute-stage sequencer: holds registered operands on ALU_32 for
// a per-class latency, then captures HI/LO or result plus flags.
module alu_exec_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int MPY_LAT = 3,
  parameter int DIV_LAT = 6
) (
  input logic          clk,
  input logic          reset,
  alu_exec_ctrl_if.slave bus
);

  localparam logic [4:0] FS_MPY = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;
  localparam logic [3:0] ALU_CNT = 4'(ALU_LAT - 1);
  localparam logic [3:0] MPY_CNT = 4'(MPY_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic        accept;
  logic        div_zero;
  logic        capture;
  logic        long_op;
  logic [3:0]  load_count;

  assign long_op = (bus.alu_FS == FS_MPY) || (bus.alu_FS == FS_DIV);

  always_comb begin
    load_count = ALU_CNT;
    if (bus.FS == FS_MPY)      load_count = MPY_CNT;
    else if (bus.FS == FS_DIV) load_count = DIV_CNT;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A divide by zero skips EXEC entirely so the requester learns of it at once.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    div_zero   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.FS == FS_DIV && bus.T == 32'd0) begin
            div_zero   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        if (count == 4'd0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= 4'd0;
      bus.div0      <= 1'b0;
      bus.alu_S     <= 32'd0;
      bus.alu_T     <= 32'd0;
      bus.alu_FS    <= 5'd0;
      bus.alu_SHAMT <= 5'd0;
      bus.result    <= 32'd0;
      bus.HI        <= 32'd0;
      bus.LO        <= 32'd0;
      bus.C         <= 1'b0;
      bus.V         <= 1'b0;
      bus.N         <= 1'b0;
      bus.Z         <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_S     <= bus.S;
        bus.alu_T     <= bus.T;
        bus.alu_FS    <= bus.FS;
        bus.alu_SHAMT <= bus.SHAMT;
        count         <= load_count;
      end else if (state == EXEC && count != 4'd0) begin
        count <= count - 4'd1;
      end

      if (div_zero)           bus.div0 <= 1'b1;
      else if (state == DONE) bus.div0 <= 1'b0;

      // The ALU leaves carry undefined for multiply/divide, so force C/V low.
      if (capture) begin
        if (long_op) begin
          bus.HI <= bus.alu_Y_hi;
          bus.LO <= bus.alu_Y_lo;
          bus.C  <= 1'b0;
          bus.V  <= 1'b0;
        end else begin
          bus.result <= bus.alu_Y_lo;
          bus.C      <= bus.alu_C;
          bus.V      <= bus.alu_V;
        end
        bus.N <= bus.alu_N;
        bus.Z <= bus.alu_Z;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized self-checking bench for alu_exec_ctrl with a behavioural ALU_32
// stand-in and a transaction-level reference model.
module tb_alu_exec_ctrl;

  localparam int ALU_LAT = 1;
  localparam int MPY_LAT = 3;
  localparam int DIV_LAT = 6;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] exp_hi, exp_lo, exp_result;
  logic        exp_c, exp_v, exp_n, exp_z;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl #(.ALU_LAT(ALU_LAT), .MPY_LAT(MPY_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {hi, lo, c, v, n, z}; multiply/divide drive garbage carry/overflow.
  function automatic logic [67:0] alu_ref(input logic [4:0] fs, input logic [4:0] sh,
                                          input logic [31:0] s, input logic [31:0] t);
    logic [31:0] hi, lo;
    logic [32:0] wide;
    logic [63:0] prod;
    logic        c, v, n, z;
    hi = 32'd0; lo = s; c = 1'b0; v = 1'b0;
    case (fs)
      5'h04: begin wide = {1'b0, s} + {1'b0, t}; lo = wide[31:0]; c = wide[32];
                   v = (s[31] == t[31]) && (lo[31] != s[31]); end
      5'h05: begin lo = s - t; c = (s >= t); v = (s[31] != t[31]) && (lo[31] != s[31]); end
      5'h08: lo = s & t;
      5'h09: lo = s | t;
      5'h0C: lo = t << sh;
      5'h0D: lo = t >> sh;
      5'h1E: begin prod = {32'd0, s} * {32'd0, t}; hi = prod[63:32]; lo = prod[31:0];
                   c = 1'b1; v = 1'b1; end
      5'h1F: begin
        if (t != 32'd0) begin lo = s / t; hi = s % t; end
        else begin lo = 32'd0; hi = 32'd0; end
        c = 1'b1; v = 1'b1;
      end
      default: lo = s;
    endcase
    if (fs == 5'h1E || fs == 5'h1F) begin n = hi[31]; z = ({hi, lo} == 64'd0); end
    else begin n = lo[31]; z = (lo == 32'd0); end
    return {hi, lo, c, v, n, z};
  endfunction

  logic [67:0] alu_out;
  always_comb begin
    alu_out      = alu_ref(bus.alu_FS, bus.alu_SHAMT, bus.alu_S, bus.alu_T);
    bus.alu_Y_hi = alu_out[67:36];
    bus.alu_Y_lo = alu_out[35:4];
    bus.alu_C    = alu_out[3];
    bus.alu_V    = alu_out[2];
    bus.alu_N    = alu_out[1];
    bus.alu_Z    = alu_out[0];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkArch(input string tag);
    checkOutput({tag, "_hi"},     bus.HI, exp_hi);
    checkOutput({tag, "_lo"},     bus.LO, exp_lo);
    checkOutput({tag, "_result"}, bus.result, exp_result);
    checkOutput({tag, "_flags"},  {bus.C, bus.V, bus.N, bus.Z}, {exp_c, exp_v, exp_n, exp_z});
  endtask

  // Issues one op, scrambles the inputs while busy, and checks latency and results.
  task automatic applyStimulus(input logic [4:0] fs, input logic [4:0] sh,
                               input logic [31:0] s, input logic [31:0] t);
    logic [67:0] r;
    int          lat, n, waited;
    bit          is_div0, seen;
    @(negedge clk);
    waited = 0;
    while (!bus.ready && waited < 30) begin @(negedge clk); waited++; end
    if (!bus.ready) checkOutput("ready_timeout", 0, 1);
    bus.start = 1'b1; bus.FS = fs; bus.SHAMT = sh; bus.S = s; bus.T = t;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.S = $urandom; bus.T = $urandom; bus.FS = 5'($urandom);
    bus.SHAMT = 5'($urandom);

    is_div0 = (fs == 5'h1F && t == 32'd0);
    lat = is_div0 ? 1 : ((fs == 5'h1E) ? MPY_LAT : (fs == 5'h1F) ? DIV_LAT : ALU_LAT) + 1;
    r = alu_ref(fs, sh, s, t);
    if (!is_div0) begin
      if (fs == 5'h1E || fs == 5'h1F) begin
        exp_hi = r[67:36]; exp_lo = r[35:4]; exp_c = 1'b0; exp_v = 1'b0;
      end else begin
        exp_result = r[35:4]; exp_c = r[3]; exp_v = r[2];
      end
      exp_n = r[1]; exp_z = r[0];
    end

    n = 1; seen = bus.done;
    if (!seen) checkOutput("busy_ready", {63'd0, bus.ready}, 64'd0);
    while (!seen && n < 30) begin
      @(posedge clk); #1; n++;
      seen = bus.done;
    end
    checkOutput("latency", n, lat);
    checkOutput("div0", {63'd0, bus.div0}, {63'd0, is_div0});
    checkOutput("hold_alu_S", bus.alu_S, s);
    checkArch("op");
    @(posedge clk); #1;
    checkOutput("done_width", {63'd0, bus.done}, 64'd0);
    checkOutput("ready_back", {63'd0, bus.ready}, 64'd1);
  endtask

  initial begin
    logic [4:0]  fs_list [9];
    logic [4:0]  fs;
    logic [31:0] t;
    logic [67:0] ra, rb;
    int          pulses;
    bit          drop;
    checks = 0; errors = 0;
    fs_list = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0C, 5'h0D, 5'h1E, 5'h1F};

    // Reset with random inputs and start asserted: reset must win.
    reset = 1'b1;
    bus.start = 1'b1; bus.FS = 5'($urandom); bus.SHAMT = 5'($urandom);
    bus.S = $urandom | 32'h1; bus.T = $urandom | 32'h1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", {63'd0, bus.ready}, 64'd1);
    checkOutput("rst_done", {63'd0, bus.done, bus.div0}, 64'd0);
    checkOutput("rst_alu", {bus.alu_S, bus.alu_T}, 64'd0);
    checkOutput("rst_alu_ctl", {54'd0, bus.alu_FS, bus.alu_SHAMT}, 64'd0);
    exp_hi = 0; exp_lo = 0; exp_result = 0; exp_c = 0; exp_v = 0; exp_n = 0; exp_z = 0;
    checkArch("rst");
    @(negedge clk);
    bus.start = 1'b0; reset = 1'b0;

    applyStimulus(5'h1E, 5'd0, 32'h0001_0000, 32'h0001_0000);
    checkOutput("mpy_hi_lo", {bus.HI, bus.LO}, {32'd1, 32'd0});
    applyStimulus(5'h1F, 5'd0, 32'd100, 32'd7);
    checkOutput("div_hi_lo", {bus.HI, bus.LO}, {32'd2, 32'd14});
    applyStimulus(5'h1F, 5'd0, 32'd100, 32'd0);
    checkOutput("div0_hi_lo", {bus.HI, bus.LO}, {32'd2, 32'd14});
    applyStimulus(5'h0C, 5'd4, 32'd0, 32'd1);
    checkOutput("shift_result", bus.result, 32'd16);

    for (int i = 0; i < 40; i++) begin
      fs = fs_list[$urandom_range(0, 8)];
      t  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      applyStimulus(fs, 5'($urandom), $urandom, t);
    end

    // Start held high across two ops; the second takes operands seen at its acceptance.
    @(negedge clk);
    bus.start = 1'b1; bus.FS = 5'h04; bus.SHAMT = 5'd0; bus.S = 32'd1000; bus.T = 32'd234;
    ra = alu_ref(5'h04, 5'd0, 32'd1000, 32'd234);
    rb = alu_ref(5'h05, 5'd0, 32'd50, 32'd80);
    @(posedge clk); #1;
    bus.FS = 5'h05; bus.S = 32'd50; bus.T = 32'd80;
    pulses = 0; drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (drop) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (pulses == 1) checkOutput("b2b_first", bus.result, ra[35:4]);
        else             checkOutput("b2b_second", {bus.result, 28'd0, bus.C, bus.V, bus.N, bus.Z},
                                     {rb[35:4], 28'd0, rb[3:0]});
      end
      if (bus.ready && pulses == 1) drop = 1'b1;
    end
    checkOutput("b2b_pulses", pulses, 2);
    exp_result = rb[35:4]; exp_c = rb[3]; exp_v = rb[2]; exp_n = rb[1]; exp_z = rb[0];

    // Reset during a divide abandons it silently.
    @(negedge clk);
    bus.start = 1'b1; bus.FS = 5'h1F; bus.S = 32'd999; bus.T = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    checkOutput("rstmid_pulses", pulses, 0);
    checkOutput("rstmid_hi_lo", {bus.HI, bus.LO}, 64'd0);
    checkOutput("rstmid_ready", {63'd0, bus.ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multicycle execute-stage sequencer for the 32-bit ALU (`ALU_32`). It accepts one operation at a time, drives `ALU_32` from registered operands, and waits a per-class number of cycles so the combinational multiply/divide paths can be constrained as multicycle paths. It then captures the results into architectural HI/LO registers or a result register plus flags, and signals completion. It sits between the decode/issue logic and `ALU_32` in the CPU datapath.

## Interface
- `ALU_LAT`, 1: cycles operands are held before capture for non-MPY/DIV ops (legal 1..15).
- `MPY_LAT`, 3: hold cycles for FS=5'h1E (legal 1..15).
- `DIV_LAT`, 6: hold cycles for FS=5'h1F (legal 1..15).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only when `ready`=1.
- `FS` in 5: function select.
- `SHAMT` in 5: shift amount.
- `S`, `T` in 32 each: operands.
- `ready` out 1: controller idle, can accept `start`.
- `done` out 1: one-cycle completion pulse.
- `div0` out 1: valid with `done`; divide by zero was aborted.
- `alu_S`, `alu_T` out 32 each: registered operands to `ALU_32`.
- `alu_FS`, `alu_SHAMT` out 5 each: registered controls to `ALU_32`.
- `alu_Y_hi`, `alu_Y_lo` in 32 each: from `ALU_32`.
- `alu_C`, `alu_V`, `alu_N`, `alu_Z` in 1 each: from `ALU_32`.
- `result` out 32: captured `alu_Y_lo` for non-MPY/DIV ops.
- `HI`, `LO` out 32 each: architectural HI/LO registers.
- `C`, `V`, `N`, `Z` out 1 each: registered flags.

## Operation
States: IDLE, EXEC, DONE. The encoding is free.

**Reset**
- Reset has priority over everything and takes effect from any state.
- State goes to IDLE; `ready`=1; `done`=0; `div0`=0.
- All data outputs, `alu_*` outputs, HI, LO, and flags reset to 0.
- An operation in flight is abandoned with no `done` pulse and no HI/LO/result update.

**IDLE**
- `ready`=1.
- On `start`=1:
  - Latch `S`, `T`, `FS`, `SHAMT` into `alu_*`.
  - Load the 4-bit counter with LAT-1, where LAT is chosen by FS: 1E→`MPY_LAT`, 1F→`DIV_LAT`, else `ALU_LAT`.
  - Go to EXEC.
- Exception: FS=1F with T=0 goes directly to DONE with `div0` set. `alu_*` is still latched. HI/LO/result/flags are unchanged.

**EXEC**
- `ready`=0. `alu_*` are stable.
- Counter decrements each cycle.
- When the counter is 0, capture results and go to DONE:
  - FS=1E/1F: HI←`alu_Y_hi`, LO←`alu_Y_lo`; `result` unchanged; C←0 (the ALU drives C as X for these ops); V←0; N, Z from ALU.
  - Otherwise: `result`←`alu_Y_lo`; C, V, N, Z from ALU; HI/LO unchanged.

**DONE**
- `done`=1 for exactly one cycle; `ready`=0. `div0` is valid this cycle and is cleared on exit.
- Go to IDLE.

**General rules**
- `start` while `ready`=0 is ignored. There is no queue; the requester must hold or reissue.
- `alu_*`, `result`, HI, LO, and flags hold their values between operations.

## Timing
- `start` is sampled at edge k in IDLE. EXEC then occupies cycles k+1 .. k+LAT.
- Capture happens at edge k+LAT+1, and `done` is high during cycle k+LAT+1.
- `ready` returns at cycle k+LAT+2. Throughput is one op per LAT+2 cycles.
- Divide by zero: `done`+`div0` are high at cycle k+1; `ready` returns at k+2.
- `start` held high continuously is accepted again on the first cycle `ready`=1. No op is lost or duplicated.
- Outputs read from `ALU_32` are sampled only at the capture edge. Paths from `alu_*` to the capture registers are multicycle (LAT).
- `start` and `reset` asserted in the same cycle: reset wins and the op is not accepted.

## Test plan
- **Reset:** assert `reset` 2 cycles with random inputs → all outputs 0, `ready`=1, `done`=0.
- **MPY:** FS=1E, S=32'h0001_0000, T=32'h0001_0000, `MPY_LAT`=3 → `done` exactly 4 cycles after `start`; HI=1, LO=0, C=0, Z=0; `result` unchanged.
- **DIV:** FS=1F, S=100, T=7, `DIV_LAT`=6 → `done` 7 cycles after `start`; LO=14, HI=2, `div0`=0. Then S=100, T=0 → `done` next cycle, `div0`=1, HI/LO still 2/14.
- **Shift:** FS=0C, T=1, SHAMT=4, `ALU_LAT`=1 → `done` 2 cycles later; `result` and flags equal a directly driven `ALU_32` reference for the same inputs.
- **Busy/back-to-back:** `start` held high across two ops with different operands; `S`/`T` changed while busy → exactly two `done` pulses; each uses the operands present at its acceptance edge.
- **Reset mid-op:** `reset` during EXEC of a DIV → no `done` pulse; HI/LO=0; `ready`=1 the cycle after reset deasserts.
